// File: rtl/output_link_buffer.sv
// Egress link buffer: FIFO from crossbar output to inter-router link
// with on/off backpressure, framing check, occupancy/ready to allocator.
package noc_params;
  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t flit_label;
    logic [13:0] payload;
  } flit_t;
endpackage

// Ports: clk, rst (sync, active-high); data_i/valid_flit_i from crossbar;
// on_off_i from neighbour; data_o/valid_flit_o link; ready_o, occupancy_o, error_o.
module output_link_buffer
  import noc_params::*;
#(
  parameter int unsigned BUFFER_SIZE = 4,
  parameter int unsigned RESERVE     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  flit_t                          data_i,
  input  logic                           valid_flit_i,
  input  logic                           on_off_i,
  output flit_t                          data_o,
  output logic                           valid_flit_o,
  output logic                           ready_o,
  output logic [$clog2(BUFFER_SIZE+1)-1:0] occupancy_o,
  output logic                           error_o
);

  localparam int unsigned PW = $clog2(BUFFER_SIZE);
  localparam int unsigned CW = $clog2(BUFFER_SIZE + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(BUFFER_SIZE);
  localparam logic [CW-1:0] READY_MAX = CW'(BUFFER_SIZE - 1 - RESERVE);

  typedef enum logic {IDLE, ACTIVE} state_t;

  flit_t           mem [BUFFER_SIZE];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  state_t          state;
  state_t          state_nxt;
  flit_t           head;
  logic            pop;
  logic            push;
  logic            overflow;
  logic            frame_err;

  assign head     = mem[rd_ptr];
  assign pop      = (count != '0) && on_off_i;
  assign push     = valid_flit_i && ((count != FULL_CNT) || pop);
  assign overflow = valid_flit_i && !push;

  assign occupancy_o = count;
  assign ready_o     = (count <= READY_MAX);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      valid_flit_o <= 1'b0;
      data_o       <= '0;
      error_o      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        data_o <= head;
      end
      valid_flit_o <= pop;
      count        <= count + CW'(push) - CW'(pop);
      if (overflow || frame_err) error_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A misplaced HEAD/HEADTAIL in ACTIVE restarts the packet.
  always_comb begin
    state_nxt = state;
    if (pop) begin
      unique case (1'b1)
        head.flit_label == HEAD:     state_nxt = ACTIVE;
        head.flit_label == HEADTAIL: state_nxt = IDLE;
        head.flit_label == TAIL:     state_nxt = IDLE;
        default:                     state_nxt = state;
      endcase
    end
  end

  always_comb begin
    frame_err = 1'b0;
    if (pop) begin
      unique case (state)
        IDLE:    frame_err = (head.flit_label == BODY) ||
                             (head.flit_label == TAIL);
        ACTIVE:  frame_err = (head.flit_label == HEAD) ||
                             (head.flit_label == HEADTAIL);
        default: frame_err = 1'b0;
      endcase
    end
  end

endmodule
